csa_sub_pipe: RTL and testbench
===============================

Name: csa_sub_pipe

Overview:
- Pipelined WIDTH-bit subtractor: Diff = A - B - Bin. It is the inverse-direction companion of the combinational carry-select adder.
- Built from GROUP-bit carry-select slices computing A + ~B + ~Bin, with one pipeline register stage per slice.
- Valid/ready handshake on both sides, so it drops into streaming arithmetic datapaths at one result per clock.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of GROUP.
- GROUP, 4, bits per carry-select slice; the pipeline has STAGES = WIDTH/GROUP stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B/Bin valid this cycle.
- in_ready  output  1  block accepts an operand set this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  Diff/Bout/Ovf valid.
- out_ready  input  1  downstream accepts the result.
- Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  borrow out; 1 when A < B + Bin (unsigned).
- Ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: one clock, rst synchronous and active-high, sampled on the rising clk edge.
  - All stage valid bits, out_valid, Diff, Bout and Ovf go to 0.
  - in_ready is 1 in the first cycle after reset.
- Accept and advance:
  - A transfer occurs when in_valid && in_ready.
  - advance = out_ready || !out_valid.
  - in_ready = advance (combinational).
  - The whole pipeline shifts only when advance is 1. When advance is 0, every stage register holds, including data and valid.
- Per-slice arithmetic:
  - Stage k (k = 0 .. STAGES-1) processes bits [k*GROUP +: GROUP].
  - Each slice precomputes two GROUP-bit sums of A_slice + ~B_slice, one for carry-in 0 and one for carry-in 1.
  - The slice then selects using the carry registered from stage k-1. Stage 0 uses carry-in = ~Bin.
- Operand skew:
  - Unprocessed upper slices of A and B travel alongside in skew registers.
  - Completed lower Diff slices also travel forward.
  - Data of different operand sets never mixes.
- Latency:
  - Exactly STAGES cycles from the accept edge to out_valid = 1, with out_ready held high. This is 4 cycles at default parameters.
  - Throughput is 1 result per cycle.
- Outputs:
  - Bout = ~carry_out of the top slice.
  - Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (Diff[WIDTH-1] != A[WIDTH-1]). A[MSB] and B[MSB] are carried through the pipeline for this term.
- Hold rule: while out_valid && !out_ready, Diff, Bout and Ovf are stable and in_ready is 0.
- Bubbles: stages whose valid bit is 0 advance freely. A bubble at the output never stalls input.
- Ordering: results emerge in acceptance order with no loss and no duplication.
- Wrap-around: Diff wraps modulo 2^WIDTH. A=0, B=1 gives 0xFFFF with Bout = 1.
- Simultaneous output pop and input accept in the same cycle is legal and sustains full rate.
- Reset mid-operation: all in-flight operands are discarded and no result from before reset ever appears on the outputs.
- in_valid = 1 while in_ready = 0: the operands are not captured. The source must hold them until accepted.

Test Plan:
- Basic subtract: A=100, B=37, Bin=0, out_ready=1 → out_valid rises exactly 4 cycles after accept; Diff=63, Bout=0, Ovf=0.
- Borrow and wrap:
  - A=0, B=1, Bin=0 → Diff=0xFFFF, Bout=1, Ovf=0.
  - A=0x1234, B=0x1234, Bin=1 → Diff=0xFFFF, Bout=1.
- Signed overflow and cross-slice borrow:
  - A=0x8000, B=0x0001 → Diff=0x7FFF, Ovf=1, Bout=0.
  - A=0x00F0, B=0x000F, Bin=1 → Diff=0x00E0, Bout=0.
- Backpressure:
  - Stimulus: stream 8 back-to-back operand sets; drop out_ready for 3 cycles once the first result is valid.
  - Required response: in_ready=0 during the stall; Diff/Bout/Ovf held stable; all 8 results in order and matching the model A-B-Bin.
- Reset mid-stream: assert rst for 1 cycle with 2 operand sets in flight → next cycle out_valid=0, Diff=0, in_ready=1; neither result ever appears; the next accepted set (A=5, B=3) yields Diff=2 after 4 cycles.
- Random regression: 1000 $random operand sets with random in_valid/out_ready toggling, compared against a behavioural A-B-Bin model including Bout and Ovf; zero mismatches.

Source files
------------

// File: rtl/csa_sub_pipe.sv
// Pipelined carry-select subtractor: Diff = A - B - Bin.
// Each GROUP-bit slice adds A + ~B using a carry-in of ~Bin, and owns one
// pipeline register stage. The slice carry is passed between stages, so a
// slice picks one of two precomputed sums. Operand bits that are not yet
// processed and Diff slices that are already done move forward with the
// carry. The whole pipeline stalls as one unit under backpressure.
module csa_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / GROUP;

  // The pipeline moves when the last stage is empty or is being drained.
  logic advance;

  // Per-stage state. Stage k holds the result after slice k is done.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] diff_q  [STAGES];
  logic [WIDTH-1:0] diff_d  [STAGES];

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [GROUP-1:0] op_a;
    logic [GROUP-1:0] op_b;
    logic             cin;
    logic [GROUP:0]   sum_c0;
    logic [GROUP:0]   sum_c1;
    logic [GROUP:0]   sum_sel;

    if (k == 0) begin : g_first
      // Slice 0 reads the live inputs. Its carry-in is the inverted borrow-in.
      assign op_a       = A[GROUP-1:0];
      assign op_b       = B[GROUP-1:0];
      assign cin        = ~Bin;
      assign valid_d[k] = in_valid;
      assign a_d[k]     = A;
      assign b_d[k]     = B;
      assign diff_d[k]  = WIDTH'(sum_sel[GROUP-1:0]);
    end else begin : g_next
      // Later slices read the skewed operands and the carry from the stage before.
      assign op_a       = a_q[k-1][k*GROUP +: GROUP];
      assign op_b       = b_q[k-1][k*GROUP +: GROUP];
      assign cin        = carry_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      // Bits above the finished slices are always zero, so OR inserts the new slice.
      assign diff_d[k]  = diff_q[k-1] | (WIDTH'(sum_sel[GROUP-1:0]) << (k*GROUP));
    end

    // Both candidate sums exist before the carry arrives. The carry only drives a mux.
    assign sum_c0     = {1'b0, op_a} + {1'b0, ~op_b};
    assign sum_c1     = {1'b0, op_a} + {1'b0, ~op_b} + {{GROUP{1'b0}}, 1'b1};
    assign sum_sel    = cin ? sum_c1 : sum_c0;
    assign carry_d[k] = sum_sel[GROUP];
  end

  // Stage registers: cleared by reset, and all shift together when advance is 1.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so each stage samples the value its neighbour had before the edge.
    if (rst) begin
      // NOTE: the data registers are reset too, not only the valid bits, so Diff reads 0 right after reset.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        diff_q[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        diff_q[k]  <= diff_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign Diff      = diff_q[STAGES-1];
  // The top carry clears after reset. Gating with valid keeps Bout at 0 in that state.
  assign Bout      = out_valid && !carry_q[STAGES-1];
  assign Ovf       = (a_q[STAGES-1][WIDTH-1] != b_q[STAGES-1][WIDTH-1]) &&
                     (diff_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Directed and random bench for csa_sub_pipe (WIDTH=16, GROUP=4).
module tb_csa_sub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        bin_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff_s;
  logic        bout_s;
  logic        ovf_s;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_popped = 0;

  csa_sub_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_s),
    .B         (b_s),
    .Bin       (bin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (diff_s),
    .Bout      (bout_s),
    .Ovf       (ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 17-bit difference, borrow taken from the top bit.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] t;
    res_t        r;
    t      = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    r.diff = t[15:0];
    r.bout = t[16];
    r.ovf  = (a[15] != b[15]) && (t[15] != a[15]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the output against the scoreboard, then step.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic ordy, output logic fired);
    in_valid  = v;
    a_s       = a;
    b_s       = b;
    bin_s     = bin;
    out_ready = ordy;
    #1;
    fired = in_valid && in_ready;
    if (out_valid) begin
      check("result_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("diff", 32'(diff_s), 32'(exp_q[0].diff));
        check("bout", 32'(bout_s), 32'(exp_q[0].bout));
        check("ovf",  32'(ovf_s),  32'(exp_q[0].ovf));
        if (!out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
        else begin
          void'(exp_q.pop_front());
          n_popped++;
        end
      end
    end
    if (fired) exp_q.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
  endtask

  // Send one set with out_ready high. Check the latency and the hand-computed result.
  task automatic send_directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic bin, input logic [15:0] e_diff,
                               input logic e_bout, input logic e_ovf);
    logic fired;
    int   lat;
    cycle(1'b1, a, b, bin, 1'b1, fired);
    check({tag, "_accept"}, 32'(fired), 32'd1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fired);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(diff_s), 32'(e_diff));
    check({tag, "_bout"}, 32'(bout_s), 32'(e_bout));
    check({tag, "_ovf"},  32'(ovf_s),  32'(e_ovf));
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fired);
  endtask

  logic [15:0] va   [8] = '{16'd10, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'h00F0, 16'hAAAA};
  logic [15:0] vb   [8] = '{16'd3,  16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h4321, 16'h000F, 16'h5555};
  logic        vbin [8] = '{1'b0,   1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};

  initial begin
    logic        fired;
    logic        ordy;
    logic        v;
    logic [15:0] cur_a;
    logic [15:0] cur_b;
    logic        cur_bin;
    int          sent;
    int          stall_left;
    int          popped0;
    bit          started;

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_s = '0; b_s = '0; bin_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff_s),    32'd0);
    check("rst_bout",      32'(bout_s),    32'd0);
    check("rst_ovf",       32'(ovf_s),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed vectors
    send_directed("basic",   16'd100,  16'd37,   1'b0, 16'd63,   1'b0, 1'b0);
    send_directed("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_directed("eq_bin",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_directed("ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_directed("xslice",  16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0, 1'b0);

    // Backpressure: eight sets back to back, with a 3-cycle stall on the first result
    sent = 0; stall_left = 0; started = 0; popped0 = n_popped;
    for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
      ordy = 1'b1;
      if (out_valid && !started) begin
        started    = 1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      cycle(sent < 8, va[sent % 8], vb[sent % 8], vbin[sent % 8], ordy, fired);
      if (fired) sent++;
    end
    check("bp_sent",    32'(sent), 32'd8);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_popped",  32'(n_popped - popped0), 32'd8);

    // Reset with two sets in flight
    cycle(1'b1, 16'd900, 16'd1, 1'b0, 1'b1, fired);
    cycle(1'b1, 16'd800, 16'd2, 1'b0, 1'b1, fired);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_diff",      32'(diff_s),    32'd0);
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    repeat (8) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fired);
    send_directed("post_rst", 16'd5, 16'd3, 1'b0, 16'd2, 1'b0, 1'b0);

    // Random regression with random valid and ready
    sent = 0; popped0 = n_popped;
    cur_a = 16'($urandom); cur_b = 16'($urandom); cur_bin = 1'($urandom);
    for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() > 0); c++) begin
      v    = (sent < 1000) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      cycle(v, cur_a, cur_b, cur_bin, ordy, fired);
      if (fired) begin
        sent++;
        cur_a = 16'($urandom); cur_b = 16'($urandom); cur_bin = 1'($urandom);
      end
    end
    check("rand_sent",    32'(sent), 32'd1000);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_popped",  32'(n_popped - popped0), 32'd1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
